ascii2bin_frame_arbiter: RTL and testbench

//  Shares one ascii_to_binary_converter between NUM_REQ ASCII character streams.

---
 rtl/ascii2bin_frame_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ascii2bin_frame_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii2bin_frame_arbiter.sv
// rtl/ascii2bin_frame_arbiter.sv - round-robin frame arbiter in front of a shared ASCII-to-binary converter
module ascii2bin_frame_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIGITS_LENGTH  = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_char,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 conv_ascii_out,
    output logic                       conv_valid_out,
    input  logic                       conv_busy_in,
    input  logic [DIGITS_LENGTH*4-1:0] conv_data_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DIGITS_LENGTH*4-1:0] res_data,
    output logic [ID_W-1:0]            res_id,
    output logic [1:0]                 res_err
);
    localparam int CNT_W  = $clog2(DIGITS_LENGTH + 1);
    localparam int BIDX_W = (DIGITS_LENGTH > 1) ? $clog2(DIGITS_LENGTH) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIGITS_LENGTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS_LENGTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_BURST, S_WAIT, S_RESULT} state_t;

    state_t              state, state_nxt;
    logic [7:0]          buffer [DIGITS_LENGTH];
    logic [CNT_W-1:0]    count;
    logic [BIDX_W-1:0]   bidx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ID_W-1:0]     owner, rr_ptr, pick;
    logic [ID_W:0]       pick_sum;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_found;
    logic                err_hex;
    logic [7:0]          owner_char;
    logic                accept, last_char, conv_done, wait_timeout;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    assign bidx         = count[BIDX_W-1:0];
    assign owner_char   = req_char[{owner, 3'b000} +: 8];
    assign accept       = (state == S_FILL) && req_valid[owner];
    assign last_char    = accept && (count == CNT_LAST);
    // First WAIT cycle (wait_cnt==0) ignores busy so the converter can register the last char.
    assign conv_done    = (wait_cnt != '0) && !conv_busy_in;
    assign wait_timeout = (wait_cnt == WAIT_LAST) && !conv_done;

    // Search starts just after the last owner, so that owner has lowest priority.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        pick_sum   = '0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pick_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (pick_sum >= (ID_W+1)'(NUM_REQ))
                pick_sum = pick_sum - (ID_W+1)'(NUM_REQ);
            pick_idx = pick_sum[ID_W-1:0];
            if (!pick_found && req_valid[pick_idx]) begin
                pick_found = 1'b1;
                pick       = pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        res_valid = 1'b0;
        case (state)
            S_IDLE:   if (pick_found) state_nxt = S_FILL;
            S_FILL: begin
                req_ready[owner] = 1'b1;
                if (last_char) state_nxt = S_BURST;
            end
            S_BURST:  if (count == CNT_FULL) state_nxt = S_WAIT;
            S_WAIT:   if (conv_done || wait_timeout) state_nxt = S_RESULT;
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner          <= '0;
            rr_ptr         <= ID_W'(NUM_REQ - 1);
            count          <= '0;
            wait_cnt       <= '0;
            err_hex        <= 1'b0;
            conv_valid_out <= 1'b0;
            conv_ascii_out <= '0;
            res_data       <= '0;
            res_id         <= '0;
            res_err        <= '0;
            for (int i = 0; i < DIGITS_LENGTH; i++)
                buffer[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (pick_found) begin
                    owner  <= pick;
                    rr_ptr <= pick;
                    count  <= '0;
                end
                S_FILL: if (accept) begin
                    buffer[bidx] <= owner_char;
                    if (!is_hex(owner_char))
                        err_hex <= 1'b1;
                    // Launch the burst on the same edge so valid stays high for exactly DIGITS_LENGTH cycles.
                    if (count == CNT_LAST) begin
                        count          <= CNT_W'(1);
                        conv_valid_out <= 1'b1;
                        conv_ascii_out <= (count == '0) ? owner_char : buffer[0];
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_BURST: begin
                    if (count == CNT_FULL) begin
                        conv_valid_out <= 1'b0;
                        conv_ascii_out <= '0;
                        wait_cnt       <= '0;
                    end else begin
                        conv_ascii_out <= buffer[bidx];
                        count          <= count + 1'b1;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (conv_done || wait_timeout) begin
                        res_data <= conv_data_in;
                        res_id   <= owner;
                        res_err  <= {wait_timeout, err_hex};
                    end
                end
                S_RESULT: if (res_ready) begin
                    err_hex <= 1'b0;
                    count   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii2bin_frame_arbiter.sv
// tb/tb_ascii2bin_frame_arbiter.sv - directed self-checking bench for ascii2bin_frame_arbiter
module tb_ascii2bin_frame_arbiter;
    localparam int NR = 4;
    localparam int DL = 8;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*8-1:0]   req_char = '0;
    logic [NR-1:0]     req_ready;
    logic [7:0]        conv_ascii_out;
    logic              conv_valid_out;
    logic              conv_busy_in;
    logic [DL*4-1:0]   conv_data_in;
    logic              res_valid;
    logic              res_ready;
    logic [DL*4-1:0]   res_data;
    logic [1:0]        res_id;
    logic [1:0]        res_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ascii2bin_frame_arbiter #(.NUM_REQ(NR), .DIGITS_LENGTH(DL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_char(req_char), .req_ready(req_ready),
        .conv_ascii_out(conv_ascii_out), .conv_valid_out(conv_valid_out),
        .conv_busy_in(conv_busy_in), .conv_data_in(conv_data_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester feeders: each pops its queue on an accepted char, optional random gaps.
    byte unsigned fq [NR][$];
    bit           gap_en [NR];
    int           gap_left [NR];
    int           acc_cnt [NR];

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i] && fq[i].size() > 0) begin
                void'(fq[i].pop_front());
                acc_cnt[i]++;
                if (gap_en[i]) gap_left[i] = $urandom_range(0, 3);
            end
        end
        #1;
        for (int i = 0; i < NR; i++) begin
            if (gap_left[i] > 0) begin
                req_valid[i] = 1'b0;
                gap_left[i]--;
            end else if (fq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_char[8*i +: 8]    = fq[i][0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Converter model: shifts in hex nibbles, busy for one cycle after the last char.
    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return 4'(c - 8'd48);
        if (c >= "A" && c <= "F") return 4'(c - 8'd55);
        if (c >= "a" && c <= "f") return 4'(c - 8'd87);
        return 4'd0;
    endfunction

    logic [31:0]  cv_shift = '0;
    int           cv_cnt = 0;
    bit           busy_one = 1'b0;
    bit           busy_stuck = 1'b0;
    byte unsigned blog[$];
    int           bcyc[$];

    assign conv_busy_in = busy_one | busy_stuck;
    assign conv_data_in = cv_shift;

    always @(negedge clk) begin
        busy_one = 1'b0;
        if (!rst_n) begin
            cv_cnt = 0;
        end else if (conv_valid_out) begin
            blog.push_back(conv_ascii_out);
            bcyc.push_back(cyc);
            cv_shift = {cv_shift[27:0], hexval(conv_ascii_out)};
            if (cv_cnt == DL - 1) begin
                cv_cnt   = 0;
                busy_one = 1'b1;
            end else begin
                cv_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] str64(input string s);
        logic [63:0] r = '0;
        for (int i = 0; i < s.len(); i++) r = {r[55:0], s[i]};
        return r;
    endfunction

    function automatic logic [63:0] log64();
        logic [63:0] r = '0;
        for (int i = 0; i < blog.size(); i++) r = {r[55:0], blog[i]};
        return r;
    endfunction

    task automatic push_frame(input int r, input string s);
        for (int i = 0; i < s.len(); i++) fq[r].push_back(s[i]);
    endtask

    task automatic clear_log();
        blog.delete();
        bcyc.delete();
    endtask

    task automatic wait_res(input string tag, input int budget, output int rcyc);
        int n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        rcyc = cyc;
    endtask

    task automatic ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic check_burst(input string tag, input string exp);
        check({tag, "_burst_len"}, 64'(blog.size()), 64'(DL));
        if (blog.size() == DL) begin
            check({tag, "_burst_contig"}, 64'(bcyc[DL-1] - bcyc[0]), 64'(DL - 1));
            check({tag, "_burst_chars"}, log64(), str64(exp));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int r = 0; r < NR; r++) begin
            fq[r].delete();
            gap_en[r]   = 1'b0;
            gap_left[r] = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int rc;
        int exp_id [5];
        int exp_dat [5];
        logic [31:0] snap_data;
        logic [1:0]  snap_id;
        bit unstable;
        bit ready_seen;
        int n;

        rst_n = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_conv_valid", 64'(conv_valid_out), 64'd0);
        check("rst_conv_ascii", 64'(conv_ascii_out), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_res_err", 64'(res_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // T1: single frame, extra trailing char must not be taken
        clear_log();
        push_frame(1, "000012349");
        wait_res("t1", 200, rc);
        check("t1_data", 64'(res_data), 64'h00001234);
        check("t1_id", 64'(res_id), 64'd1);
        check("t1_err", 64'(res_err), 64'd0);
        check("t1_accepted", 64'(acc_cnt[1]), 64'd8);
        check("t1_leftover", 64'(fq[1].size()), 64'd1);
        check("t1_ready_low", 64'(req_ready), 64'd0);
        check_burst("t1", "00001234");
        fq[1].delete();
        ack();
        check("t1_res_valid_drop", 64'(res_valid), 64'd0);

        // T2: round-robin from reset, second req0 frame after req3
        do_reset();
        push_frame(0, "00000000");
        push_frame(1, "00000001");
        push_frame(2, "00000002");
        push_frame(3, "00000003");
        push_frame(0, "00000005");
        exp_id  = '{0, 1, 2, 3, 0};
        exp_dat = '{0, 1, 2, 3, 5};
        for (int k = 0; k < 5; k++) begin
            wait_res($sformatf("t2_%0d", k), 200, rc);
            check($sformatf("t2_id_%0d", k), 64'(res_id), 64'(exp_id[k]));
            check($sformatf("t2_data_%0d", k), 64'(res_data), 64'(exp_dat[k]));
            ack();
        end

        // T3: gaps in the input, burst must still be contiguous
        clear_log();
        gap_en[2] = 1'b1;
        push_frame(2, "13579BDF");
        wait_res("t3", 300, rc);
        check("t3_data", 64'(res_data), 64'h13579BDF);
        check("t3_id", 64'(res_id), 64'd2);
        check_burst("t3", "13579BDF");
        ack();
        gap_en[2] = 1'b0;

        // T4: invalid hex char, then WAIT timeout
        push_frame(3, "12G45678");
        wait_res("t4a", 200, rc);
        check("t4a_err", 64'(res_err), 64'd1);
        check("t4a_id", 64'(res_id), 64'd3);
        ack();

        busy_stuck = 1'b1;
        clear_log();
        push_frame(0, "00000042");
        wait_res("t4b", 300, rc);
        check("t4b_err", 64'(res_err), 64'd2);
        check("t4b_id", 64'(res_id), 64'd0);
        if (bcyc.size() == DL)
            check("t4b_timeout_cycles", 64'(rc - bcyc[DL-1] - 1), 64'(TO));
        else
            check("t4b_burst_len", 64'(bcyc.size()), 64'(DL));
        ack();
        busy_stuck = 1'b0;

        // T5: result backpressure holds everything, then next grant proceeds
        push_frame(1, "0000ABCD");
        wait_res("t5", 200, rc);
        snap_data = res_data;
        snap_id   = res_id;
        push_frame(2, "00000077");
        unstable   = 1'b0;
        ready_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!res_valid || res_data !== snap_data || res_id !== snap_id || res_err !== 2'b00)
                unstable = 1'b1;
            if (req_ready != '0) ready_seen = 1'b1;
        end
        check("t5_stable", 64'(unstable), 64'd0);
        check("t5_no_ready", 64'(ready_seen), 64'd0);
        check("t5_data", 64'(res_data), 64'h0000ABCD);
        check("t5_id", 64'(res_id), 64'd1);
        ack();
        wait_res("t5b", 200, rc);
        check("t5b_id", 64'(res_id), 64'd2);
        check("t5b_data", 64'(res_data), 64'h00000077);
        ack();

        // T6: reset during the burst, then a clean frame from req0
        clear_log();
        push_frame(0, "00000099");
        n = 0;
        while (blog.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        check("t6_burst_reached", 64'(blog.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        check("t6_conv_valid_drop", 64'(conv_valid_out), 64'd0);
        check("t6_req_ready_drop", 64'(req_ready), 64'd0);
        for (int r = 0; r < NR; r++) fq[r].delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        push_frame(0, "00000314");
        wait_res("t6", 200, rc);
        check("t6_data", 64'(res_data), 64'h00000314);
        check("t6_id", 64'(res_id), 64'd0);
        check("t6_err", 64'(res_err), 64'd0);
        check_burst("t6", "00000314");
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
